core_alu_issue: RTL and testbench
=================================

Name: core_alu_issue

Overview:
- Decode/issue stage that drives the operand interface of the RV64 integer ALU.
- Takes a raw 32-bit instruction plus register-file read data and PC, and decodes the instruction into ALU operands, a 4-bit ALU control code and a word flag.
- Presents the result on a registered valid/ready output stage.
- Sits between operand fetch and execute in each core of the multicore pipeline.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.

Ports:
- i_clk  input  1  core clock.
- i_rst_n  input  1  reset.
- i_valid  input  1  upstream instruction valid.
- o_ready  output  1  stage can accept an instruction.
- i_instr  input  32  raw instruction.
- i_rs1_data  input  XLEN  rs1 read data.
- i_rs2_data  input  XLEN  rs2 read data.
- i_pc  input  XLEN  instruction PC.
- o_valid  output  1  issue slot valid.
- i_ready  input  1  execute stage accepts.
- o_alu_srcA  output  XLEN  ALU operand A.
- o_alu_srcB  output  XLEN  ALU operand B.
- o_alu_control  output  4  ALU op code.
- o_alu_isword  output  1  32-bit (W) operation.
- o_rd  output  5  destination register.
- o_illegal  output  1  instruction not decodable by this stage.

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst_n is asynchronous and active-low. All outputs are registered.
- Reset values: o_valid=0, o_ready=1, all data outputs 0.
- Handshake:
  - Input transfer occurs when i_valid && o_ready.
  - Output transfer occurs when o_valid && i_ready.
  - Latency is 1 cycle from input transfer to o_valid.
  - While o_valid && !i_ready, every output is held stable.
  - Order is preserved; there is no loss and no duplication.
- Control codes: add 0000, sub 0001, and 0010, or 0011, sll 0100, slt 0101, xor 0110, srl 0111, sltu 1000, sra 1111.
- OP (0110011):
  - srcA=rs1, srcB=rs2, control from funct3.
  - funct7=0100000 is legal only with funct3 000 (sub) or 101 (sra).
  - Any other funct7 except 0000000 is illegal.
- OP-IMM (0010011):
  - srcB = sign-extended I-immediate.
  - Shifts: srcB = zero-extended shamt[5:0].
  - slli requires funct6=000000.
  - srli/srai require funct6=000000 / 010000 respectively.
- OP-32 (0111011): isword=1.
  - Legal funct3 values: 000 (add/sub), 001 (sll, funct7=0), 101 (srl/sra).
- OP-IMM-32 (0011011): isword=1.
  - Legal funct3 values: 000, 001, 101.
  - Shifts require instr[25]=0; srcB = zero-extended shamt[4:0].
- LUI (0110111): srcA=0, srcB = sign-extended U-immediate, add.
- AUIPC (0010111): srcA=i_pc, srcB = sign-extended U-immediate, add.
- Anything else is illegal.
- Illegal instructions still issue: o_illegal=1, control=0000, srcA=srcB=0, isword=0, rd passed through.
- Skid storage: main register plus a 1-entry skid register.
  - o_ready is registered and equals !skid_full.
  - Skid fills when an input is accepted while main is valid and !i_ready.
  - When main drains, skid moves to main in the same cycle.
  - Full throughput: 1 instruction per cycle with i_ready held 1.
  - Simultaneous accept and drain with skid empty: main reloads directly and skid stays empty.
- Reset mid-operation: both entries are discarded and reset values apply immediately.

Optional Feature:
- Macro: CORE_ALU_ISSUE_SKID_EN.
- Defined: 2-entry behaviour as above; o_ready is registered (no i_ready→o_ready combinational path).
- Undefined: skid register is removed; o_ready = !o_valid || i_ready (combinational). Throughput and ordering are unchanged.
- Both builds must pass the full test plan.

Test Plan:
- ADD, i_instr=0x002081B3, rs1=5, rs2=7 → next cycle o_valid=1, srcA=5, srcB=7, control=0000, isword=0, rd=3, illegal=0.
- ADDIW, i_instr=0xFFF3029B, rs1=0x1_0000_0000 → srcB=0xFFFF_FFFF_FFFF_FFFF, control=0000, isword=1, rd=5.
- SRAI, i_instr=0x43F0D093 → srcB=0x3F, control=1111, isword=0. With instr[30] cleared (0x03F0D093) → control=0111.
- Backpressure:
  - Stimulus: 3 back-to-back valid instructions with i_ready=0 for 3 cycles, then 1.
  - Skid build: o_ready=0 after the second accept; outputs stable while stalled; all three issue in order; no drop.
  - Non-skid build: o_ready=0 after the first accept.
- Illegal: i_instr=0x00000000, then SLLIW with instr[25]=1 (0x0210109B) → o_illegal=1, control=0000, srcA=srcB=0.
- Assert i_rst_n=0 while stalled with skid full → o_valid=0 and o_ready=1 immediately; no stale instruction issues after release.

Source files
------------

// File: rtl/core_alu_issue_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | core_alu_issue_if : issue-stage handshake and operand bus                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface core_alu_issue_if #(
    parameter int XLEN = 64
);
    logic            i_valid;
    logic            o_ready;
    logic [31:0]     i_instr;
    logic [XLEN-1:0] i_rs1_data;
    logic [XLEN-1:0] i_rs2_data;
    logic [XLEN-1:0] i_pc;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_alu_srcA;
    logic [XLEN-1:0] o_alu_srcB;
    logic [3:0]      o_alu_control;
    logic            o_alu_isword;
    logic [4:0]      o_rd;
    logic            o_illegal;

    modport master (
        output i_valid, i_instr, i_rs1_data, i_rs2_data, i_pc, i_ready,
        input  o_ready, o_valid, o_alu_srcA, o_alu_srcB, o_alu_control,
               o_alu_isword, o_rd, o_illegal
    );

    modport slave (
        input  i_valid, i_instr, i_rs1_data, i_rs2_data, i_pc, i_ready,
        output o_ready, o_valid, o_alu_srcA, o_alu_srcB, o_alu_control,
               o_alu_isword, o_rd, o_illegal
    );
endinterface
`default_nettype wire

// File: rtl/core_alu_issue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | core_alu_issue : RV64 ALU decode/issue stage, registered valid/ready out |
// | Option macro CORE_ALU_ISSUE_SKID_EN adds a skid entry (registered ready) |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module core_alu_issue #(
    parameter int XLEN = 64
) (
    input  wire logic       i_clk,
    input  wire logic       i_rst_n,
    core_alu_issue_if.slave bus
);
    localparam logic [6:0] c_OP        = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_32     = 7'b0111011;
    localparam logic [6:0] c_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] c_LUI       = 7'b0110111;
    localparam logic [6:0] c_AUIPC     = 7'b0010111;
    localparam logic [6:0] c_F7_ALT    = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0] src_a;
        logic [XLEN-1:0] src_b;
        logic [3:0]      ctrl;
        logic            isword;
        logic [4:0]      rd;
        logic            illegal;
    } entry_t;

    function automatic logic [3:0] f_ctrl(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  f_ctrl = alt ? 4'b0001 : 4'b0000;
            3'b001:  f_ctrl = 4'b0100;
            3'b010:  f_ctrl = 4'b0101;
            3'b011:  f_ctrl = 4'b1000;
            3'b100:  f_ctrl = 4'b0110;
            3'b101:  f_ctrl = alt ? 4'b1111 : 4'b0111;
            3'b110:  f_ctrl = 4'b0011;
            default: f_ctrl = 4'b0010;
        endcase
    endfunction

    logic [31:0]     w_instr;
    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_u;
    logic            w_legal;
    entry_t          w_dec;

    assign w_instr  = bus.i_instr;
    assign w_opcode = w_instr[6:0];
    assign w_f3     = w_instr[14:12];
    assign w_f7     = w_instr[31:25];
    assign w_imm_i  = {{(XLEN-12){w_instr[31]}}, w_instr[31:20]};
    assign w_imm_u  = {{(XLEN-32){w_instr[31]}}, w_instr[31:12], 12'b0};

    always_comb begin
        w_dec        = '0;
        w_legal      = 1'b0;
        w_dec.src_a  = bus.i_rs1_data;
        w_dec.ctrl   = f_ctrl(w_f3, 1'b0);
        case (w_opcode)
            c_OP: begin
                w_dec.src_b = bus.i_rs2_data;
                w_dec.ctrl  = f_ctrl(w_f3, w_f7[5]);
                w_legal     = (w_f7 == 7'b0) ||
                              ((w_f7 == c_F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
            end
            c_OP_IMM: begin
                w_dec.src_b = w_imm_i;
                w_legal     = 1'b1;
                if (w_f3 == 3'b001) begin
                    w_dec.src_b = {{(XLEN-6){1'b0}}, w_instr[25:20]};
                    w_legal     = (w_instr[31:26] == 6'b000000);
                end else if (w_f3 == 3'b101) begin
                    w_dec.src_b = {{(XLEN-6){1'b0}}, w_instr[25:20]};
                    w_dec.ctrl  = f_ctrl(w_f3, w_instr[30]);
                    w_legal     = (w_instr[31:26] == 6'b000000) ||
                                  (w_instr[31:26] == 6'b010000);
                end
            end
            c_OP_32: begin
                w_dec.isword = 1'b1;
                w_dec.src_b  = bus.i_rs2_data;
                w_dec.ctrl   = f_ctrl(w_f3, w_f7[5]);
                w_legal      = (((w_f3 == 3'b000) || (w_f3 == 3'b101)) &&
                                ((w_f7 == 7'b0) || (w_f7 == c_F7_ALT))) ||
                               ((w_f3 == 3'b001) && (w_f7 == 7'b0));
            end
            c_OP_IMM_32: begin
                w_dec.isword = 1'b1;
                w_dec.src_b  = w_imm_i;
                w_dec.ctrl   = f_ctrl(w_f3, w_instr[30]);
                if (w_f3 == 3'b000) begin
                    w_dec.ctrl = 4'b0000;
                    w_legal    = 1'b1;
                end else if (w_f3 == 3'b001) begin
                    w_dec.src_b = {{(XLEN-5){1'b0}}, w_instr[24:20]};
                    w_legal     = (w_f7 == 7'b0);
                end else if (w_f3 == 3'b101) begin
                    w_dec.src_b = {{(XLEN-5){1'b0}}, w_instr[24:20]};
                    w_legal     = (w_f7 == 7'b0) || (w_f7 == c_F7_ALT);
                end
            end
            c_LUI, c_AUIPC: begin
                w_dec.src_a = (w_opcode == c_AUIPC) ? bus.i_pc : '0;
                w_dec.src_b = w_imm_u;
                w_dec.ctrl  = 4'b0000;
                w_legal     = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
        // Illegal encodings still flow downstream so the trap is raised in order.
        if (!w_legal) begin
            w_dec         = '0;
            w_dec.illegal = 1'b1;
        end
        w_dec.rd = w_instr[11:7];
    end

    logic   main_valid_q, main_valid_d;
    entry_t main_q, main_d;
    logic   w_accept;
    logic   w_drain;

    assign w_drain = main_valid_q && bus.i_ready;

`ifdef CORE_ALU_ISSUE_SKID_EN
    logic   skid_valid_q, skid_valid_d;
    entry_t skid_q, skid_d;
    logic   ready_q;

    assign bus.o_ready = ready_q;
    assign w_accept    = bus.i_valid && ready_q;

    // Skid can only be full while ready is low, so no accept collides with it.
    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (!main_valid_q || w_drain) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = w_accept;
                if (w_accept) main_d = w_dec;
            end
        end else if (w_accept) begin
            skid_valid_d = 1'b1;
            skid_d       = w_dec;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_valid_q <= 1'b0;
            main_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            ready_q      <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_q       <= main_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            ready_q      <= !skid_valid_d;
        end
    end
`else
    assign bus.o_ready = !main_valid_q || bus.i_ready;
    assign w_accept    = bus.i_valid && bus.o_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        if (w_accept) begin
            main_valid_d = 1'b1;
            main_d       = w_dec;
        end else if (w_drain) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_valid_q <= 1'b0;
            main_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_q       <= main_d;
        end
    end
`endif

    assign bus.o_valid       = main_valid_q;
    assign bus.o_alu_srcA    = main_q.src_a;
    assign bus.o_alu_srcB    = main_q.src_b;
    assign bus.o_alu_control = main_q.ctrl;
    assign bus.o_alu_isword  = main_q.isword;
    assign bus.o_rd          = main_q.rd;
    assign bus.o_illegal     = main_q.illegal;
endmodule
`default_nettype wire

// File: tb/tb_core_alu_issue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_core_alu_issue : scoreboard bench for core_alu_issue                  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_core_alu_issue;
    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    core_alu_issue_if #(.XLEN(XLEN)) bus ();
    core_alu_issue #(.XLEN(XLEN)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  ctrl;
        logic        w;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t q[$];
    exp_t m_act, m_exp;
    int   n_cmp = 0;
    int   n_err = 0;

`ifdef CORE_ALU_ISSUE_SKID_EN
    localparam logic c_SKID = 1'b1;
`else
    localparam logic c_SKID = 1'b0;
`endif

    function automatic exp_t mk(input logic [63:0] a, input logic [63:0] b,
                                input logic [3:0] c, input logic w,
                                input logic [4:0] rd, input logic ill);
        exp_t e;
        e.a = a; e.b = b; e.ctrl = c; e.w = w; e.rd = rd; e.ill = ill;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completed output transfer is matched against the queue head.
    always @(negedge clk) begin
        if (rst_n && bus.o_valid && bus.i_ready) begin
            m_act = {bus.o_alu_srcA, bus.o_alu_srcB, bus.o_alu_control,
                     bus.o_alu_isword, bus.o_rd, bus.o_illegal};
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL issue_unexpected: got %h expected nothing", m_act);
            end else begin
                m_exp = q.pop_front();
                if (m_act !== m_exp) begin
                    n_err++;
                    $display("FAIL issue: got a=%h b=%h c=%b w=%b rd=%0d ill=%b expected a=%h b=%h c=%b w=%b rd=%0d ill=%b",
                             m_act.a, m_act.b, m_act.ctrl, m_act.w, m_act.rd, m_act.ill,
                             m_exp.a, m_exp.b, m_exp.ctrl, m_exp.w, m_exp.rd, m_exp.ill);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] ins, input logic [63:0] r1, input logic [63:0] r2,
                        input logic [63:0] pc, input exp_t e, output int cycles);
        logic acc;
        acc    = 1'b0;
        cycles = 0;
        bus.i_valid    = 1'b1;
        bus.i_instr    = ins;
        bus.i_rs1_data = r1;
        bus.i_rs2_data = r2;
        bus.i_pc       = pc;
        while (!acc && cycles < 50) begin
            @(negedge clk);
            acc = bus.o_ready;
            @(posedge clk);
            #1;
            cycles++;
        end
        bus.i_valid = 1'b0;
        if (acc) begin
            q.push_back(e);
        end else begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got no accept expected accept for %h", ins);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_pending", 64'(q.size()), 64'd0);
    endtask

    int   cyc;
    exp_t ea, eb, ec;

    initial begin
        bus.i_valid = 1'b0; bus.i_instr = '0; bus.i_rs1_data = '0;
        bus.i_rs2_data = '0; bus.i_pc = '0; bus.i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o_valid", bus.o_valid, 1'b0);
        chk("rst_o_ready", bus.o_ready, 1'b1);
        chk("rst_srcA", bus.o_alu_srcA, 64'd0);
        chk("rst_srcB", bus.o_alu_srcB, 64'd0);
        chk("rst_ctrl", bus.o_alu_control, 4'd0);
        chk("rst_rd_ill_w", {bus.o_rd, bus.o_illegal, bus.o_alu_isword}, 7'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(32'h002081B3, 64'd5, 64'd7, 64'h1000, mk(64'd5, 64'd7, 4'b0000, 1'b0, 5'd3, 1'b0), cyc);
        chk("add_latency_valid", bus.o_valid, 1'b1);
        send(32'hFFF3029B, 64'h1_0000_0000, 64'd9, 64'h1004,
             mk(64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000, 1'b1, 5'd5, 1'b0), cyc);
        chk("throughput_addiw", 64'(cyc), 64'd1);
        send(32'h43F0D093, 64'h8000_0000_0000_0000, 64'd0, 64'h1008,
             mk(64'h8000_0000_0000_0000, 64'h3F, 4'b1111, 1'b0, 5'd1, 1'b0), cyc);
        chk("throughput_srai", 64'(cyc), 64'd1);
        send(32'h03F0D093, 64'h1234, 64'd0, 64'h100C, mk(64'h1234, 64'h3F, 4'b0111, 1'b0, 5'd1, 1'b0), cyc);
        send(32'h40208133, 64'd10, 64'd3, 64'h1010, mk(64'd10, 64'd3, 4'b0001, 1'b0, 5'd2, 1'b0), cyc);
        send(32'h123450B7, 64'hDEAD, 64'hBEEF, 64'h1014, mk(64'd0, 64'h1234_5000, 4'b0000, 1'b0, 5'd1, 1'b0), cyc);
        send(32'h80000097, 64'hDEAD, 64'hBEEF, 64'h4000,
             mk(64'h4000, 64'hFFFF_FFFF_8000_0000, 4'b0000, 1'b0, 5'd1, 1'b0), cyc);
        send(32'h00000000, 64'd5, 64'd6, 64'h1018, mk(64'd0, 64'd0, 4'b0000, 1'b0, 5'd0, 1'b1), cyc);
        send(32'h0210109B, 64'd5, 64'd6, 64'h101C, mk(64'd0, 64'd0, 4'b0000, 1'b0, 5'd1, 1'b1), cyc);
        send(32'h022081B3, 64'd5, 64'd6, 64'h1020, mk(64'd0, 64'd0, 4'b0000, 1'b0, 5'd3, 1'b1), cyc);
        drain();

        ea = mk(64'h11, 64'h22, 4'b0000, 1'b0, 5'd3, 1'b0);
        eb = mk(64'h33, 64'h4, 4'b0001, 1'b0, 5'd2, 1'b0);
        ec = mk(64'h8000, 64'hFFFF_FFFF_8000_0000, 4'b0000, 1'b0, 5'd1, 1'b0);
        bus.i_ready = 1'b0;
        fork
            begin
                send(32'h002081B3, 64'h11, 64'h22, 64'h0, ea, cyc);
                send(32'h40208133, 64'h33, 64'h4, 64'h0, eb, cyc);
                send(32'h80000097, 64'h0, 64'h0, 64'h8000, ec, cyc);
            end
            begin
                @(posedge clk);
                #1;
                chk("bp1_o_ready", bus.o_ready, c_SKID);
                chk("bp1_o_valid", bus.o_valid, 1'b1);
                @(posedge clk);
                #1;
                chk("bp2_o_ready", bus.o_ready, 1'b0);
                chk("bp2_hold_srcA", bus.o_alu_srcA, ea.a);
                @(posedge clk);
                #1;
                chk("bp3_hold_srcB", bus.o_alu_srcB, ea.b);
                chk("bp3_hold_rd", bus.o_rd, ea.rd);
                bus.i_ready = 1'b1;
            end
        join
        drain();

        bus.i_ready    = 1'b0;
        bus.i_valid    = 1'b1;
        bus.i_instr    = 32'h002081B3;
        bus.i_rs1_data = 64'h77;
        bus.i_rs2_data = 64'h88;
        @(posedge clk);
        #1;
        bus.i_instr = 32'h40208133;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        chk("stall_o_valid", bus.o_valid, 1'b1);
        chk("stall_o_ready", bus.o_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_o_valid", bus.o_valid, 1'b0);
        chk("async_rst_o_ready", bus.o_ready, 1'b1);
        chk("async_rst_srcA", bus.o_alu_srcA, 64'd0);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        bus.i_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_no_stale", bus.o_valid, 1'b0);

        send(32'h002081B3, 64'd1, 64'd2, 64'h0, mk(64'd1, 64'd2, 4'b0000, 1'b0, 5'd3, 1'b0), cyc);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
